// File: rtl/tach_pkg.sv
// Shared quadrature-encoder definitions for tachometer_emulator and tachometer_interface.
package tach_pkg;

  typedef enum logic [1:0] {
    QUAD_00 = 2'b00,
    QUAD_01 = 2'b01,
    QUAD_10 = 2'b10,
    QUAD_11 = 2'b11
  } quad_state_t;

  localparam quad_state_t QUAD_RESET_STATE = QUAD_01;

  // Next {A,B} indexed by the current {A,B}; forward ring is 01 -> 11 -> 10 -> 00
  localparam logic [3:0][1:0] QUAD_FWD_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};
  localparam logic [3:0][1:0] QUAD_REV_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};

  function automatic logic [63:0] calc_inc_per_rpm(input int unsigned acc_w,
                                                   input longint unsigned clk_hz,
                                                   input int unsigned ppr);
    logic [63:0] num;
    logic [63:0] den;
    num = (64'd1 << acc_w) * 64'(4 * ppr);
    den = 64'd60 * 64'(clk_hz);
    return (num + den / 64'd2) / den;
  endfunction

endpackage

// File: rtl/tachometer_emulator_phase_accumulator.sv
// Phase accumulator for the tachometer emulator: clamps the commanded rpm, registers the
// per-cycle increment and flags one quadrature edge per accumulator carry.
module phase_accumulator #(
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned MAX_RPM     = 1023,
  parameter logic [63:0] INC_PER_RPM = 64'd71583
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       enable_in,
  input  logic [9:0] target_rpm_in,
  output logic       carry_out
);

  // An increment at or above the full scale could need two edges in one cycle.
  if (64'(MAX_RPM) * INC_PER_RPM >= (64'd1 << ACC_W)) begin : g_inc_overflow
    $error("phase_accumulator: MAX_RPM * INC_PER_RPM must stay below 2**ACC_W");
  end

  localparam logic [ACC_W-1:0] INC_W = ACC_W'(INC_PER_RPM);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic [9:0]       w_rpm_clamped;
  logic [ACC_W-1:0] w_inc_next;
  logic [ACC_W:0]   w_sum;

  assign w_rpm_clamped = ({22'd0, target_rpm_in} > MAX_RPM) ? 10'(MAX_RPM) : target_rpm_in;
  assign w_inc_next    = ACC_W'(w_rpm_clamped) * INC_W;
  assign w_sum         = {1'b0, r_acc} + {1'b0, r_inc};
  assign carry_out     = enable_in & w_sum[ACC_W];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_acc <= '0;
      r_inc <= '0;
    end else begin
      r_inc <= w_inc_next;
      if (enable_in) begin
        r_acc <= w_sum[ACC_W-1:0];
      end else begin
        r_acc <= '0;
      end
    end
  end

endmodule

// File: rtl/tachometer_emulator.sv
// Quadrature encoder emulator: turns a commanded rpm and direction into A/B tachometer edges.
// Optional once-per-revolution index output is built only when TACH_EMU_INDEX_EN is defined.
module tachometer_emulator
  import tach_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 125_000_000,
  parameter int unsigned PULSES_PER_REV = 12,
  parameter int unsigned MAX_RPM        = 1023,
  parameter int unsigned ACC_W          = 32
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic [9:0]  target_rpm_in,
  input  logic        direction_in,
  output logic        tachometer_out_a,
  output logic        tachometer_out_b,
  output logic        edge_strobe_out,
  output logic [15:0] position_out,
  output logic        index_out
);

  localparam logic [63:0]      INC_PER_RPM   = calc_inc_per_rpm(ACC_W, CLK_FREQ_HZ, PULSES_PER_REV);
  localparam int unsigned      EDGES_PER_REV = 4 * PULSES_PER_REV;
  localparam int unsigned      REV_W         = $clog2(EDGES_PER_REV);
  localparam logic [REV_W-1:0] REV_LAST      = REV_W'(EDGES_PER_REV - 1);

  logic             w_carry;
  quad_state_t      r_state;
  logic             r_strobe;
  logic [15:0]      r_pos;
  logic [REV_W-1:0] r_rev;
  quad_state_t      w_next_state;
  logic [REV_W-1:0] w_next_rev;
  logic [15:0]      w_next_pos;

  phase_accumulator #(
    .ACC_W       (ACC_W),
    .MAX_RPM     (MAX_RPM),
    .INC_PER_RPM (INC_PER_RPM)
  ) u_phase_acc (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .enable_in     (enable_in),
    .target_rpm_in (target_rpm_in),
    .carry_out     (w_carry)
  );

  // Direction only picks which neighbour in the Gray ring comes next, so a reversal never skips a state.
  always_comb begin
    w_next_state = r_state;
    w_next_rev   = r_rev;
    w_next_pos   = r_pos;
    if (direction_in) begin
      w_next_state = quad_state_t'(QUAD_REV_NEXT[r_state]);
      w_next_rev   = (r_rev == '0) ? REV_LAST : r_rev - REV_W'(1);
      w_next_pos   = r_pos - 16'd1;
    end else begin
      w_next_state = quad_state_t'(QUAD_FWD_NEXT[r_state]);
      w_next_rev   = (r_rev == REV_LAST) ? '0 : r_rev + REV_W'(1);
      w_next_pos   = r_pos + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= QUAD_RESET_STATE;
      r_strobe <= 1'b0;
      r_pos    <= '0;
      r_rev    <= '0;
    end else begin
      r_strobe <= w_carry;
      if (w_carry) begin
        r_state <= w_next_state;
        r_pos   <= w_next_pos;
        r_rev   <= w_next_rev;
      end
    end
  end

  assign tachometer_out_a = r_state[1];
  assign tachometer_out_b = r_state[0];
  assign edge_strobe_out  = r_strobe;
  assign position_out     = r_pos;

`ifdef TACH_EMU_INDEX_EN
  logic r_index;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_index <= 1'b0;
    end else if (w_carry) begin
      r_index <= (w_next_rev == '0) && (w_next_state == QUAD_01);
    end
  end

  assign index_out = r_index;
`else
  assign index_out = 1'b0;
`endif

endmodule

// File: tb/tb_tachometer_emulator.sv
// Directed bench for tachometer_emulator: segment table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_tachometer_emulator;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable_in = 1'b0;
  logic        direction_in = 1'b0;
  logic [9:0]  target_rpm_in = 10'd0;

  logic        a, b, strobe, idx;
  logic [15:0] pos;
  logic        ca, cb, cstrobe, cidx;
  logic [15:0] cpos;

  always #5 clk = ~clk;

  tachometer_emulator #(
    .CLK_FREQ_HZ(48_000), .PULSES_PER_REV(12), .MAX_RPM(1023), .ACC_W(32)
  ) dut (
    .clk_in(clk), .reset_in(reset_in), .enable_in(enable_in),
    .target_rpm_in(target_rpm_in), .direction_in(direction_in),
    .tachometer_out_a(a), .tachometer_out_b(b), .edge_strobe_out(strobe),
    .position_out(pos), .index_out(idx)
  );

  tachometer_emulator #(
    .CLK_FREQ_HZ(48_000), .PULSES_PER_REV(12), .MAX_RPM(500), .ACC_W(32)
  ) dut_c (
    .clk_in(clk), .reset_in(reset_in), .enable_in(enable_in),
    .target_rpm_in(target_rpm_in), .direction_in(direction_in),
    .tachometer_out_a(ca), .tachometer_out_b(cb), .edge_strobe_out(cstrobe),
    .position_out(cpos), .index_out(cidx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: forward ring 01,11,10,00; updated on every observed strobe
  logic [1:0]  ring [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  int          m_idx = 0;
  int          m_rev = 0;
  logic [15:0] m_pos = 16'd0;
  logic        m_index = 1'b0;
  logic        rst_prev = 1'b1;
  logic        dir_prev = 1'b0;
  logic        idx_prev = 1'b0;
  int          idx_pulses = 0;

  always @(negedge clk) begin
    if (rst_prev) begin
      m_idx = 0; m_rev = 0; m_pos = 16'd0; m_index = 1'b0;
    end else if (strobe) begin
      if (dir_prev) begin
        m_idx = (m_idx + 3) % 4; m_rev = (m_rev + 47) % 48; m_pos = m_pos - 16'd1;
      end else begin
        m_idx = (m_idx + 1) % 4; m_rev = (m_rev + 1) % 48; m_pos = m_pos + 16'd1;
      end
      m_index = (m_rev == 0) && (ring[m_idx] == 2'b01);
    end
    check("model_ab", {a, b}, ring[m_idx]);
    check("model_pos", pos, m_pos);
`ifdef TACH_EMU_INDEX_EN
    check("model_index", idx, m_index);
`else
    check("index_tied_low", idx, 0);
`endif
    if (idx && !idx_prev) idx_pulses++;
    idx_prev = idx;
    rst_prev = reset_in;
    dir_prev = direction_in;
  end

  task automatic wait_strobe(input bit clamp, input int bound, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!(clamp ? cstrobe : strobe) && cyc < bound);
    if (!(clamp ? cstrobe : strobe)) begin
      n_checks++; n_fail++;
      $display("FAIL edge_timeout: no edge within %0d cycles", bound);
    end
  endtask

  task automatic count_strobes(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (strobe) cnt++;
    end
  endtask

  typedef struct {
    logic [9:0]  rpm;
    logic        dir;
    int          n_edges;
    int          first_lat;
    int          sp_lo;
    int          sp_hi;
    logic [15:0] exp_pos;
    logic [1:0]  exp_ab;
  } seg_t;

  seg_t segs [4];

  initial begin
    int cyc, cnt, main_cnt, first_main;

    segs[0] = '{rpm: 10'd600,  dir: 1'b0, n_edges: 48, first_lat: 101, sp_lo: 99,  sp_hi: 101, exp_pos: 16'd48, exp_ab: 2'b01};
    segs[1] = '{rpm: 10'd600,  dir: 1'b1, n_edges: 24, first_lat: 0,   sp_lo: 99,  sp_hi: 101, exp_pos: 16'd24, exp_ab: 2'b01};
    segs[2] = '{rpm: 10'd1023, dir: 1'b0, n_edges: 20, first_lat: 0,   sp_lo: 58,  sp_hi: 59,  exp_pos: 16'd44, exp_ab: 2'b01};
    segs[3] = '{rpm: 10'd300,  dir: 1'b1, n_edges: 8,  first_lat: 0,   sp_lo: 199, sp_hi: 201, exp_pos: 16'd36, exp_ab: 2'b01};

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", a, 0);
    check("reset_b", b, 1);
    check("reset_pos", pos, 0);
    check("reset_strobe", strobe, 0);
    check("reset_index", idx, 0);
    @(posedge clk); #1 reset_in = 1'b0;

    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      target_rpm_in = segs[s].rpm;
      direction_in  = segs[s].dir;
      enable_in     = 1'b1;
      wait_strobe(1'b0, 400, cyc);
      if (segs[s].first_lat != 0) check($sformatf("first_edge_seg%0d", s), cyc, segs[s].first_lat);
      for (int e = 1; e < segs[s].n_edges; e++) begin
        wait_strobe(1'b0, 400, cyc);
        check_range($sformatf("spacing_seg%0d", s), cyc, segs[s].sp_lo, segs[s].sp_hi);
      end
      check($sformatf("pos_seg%0d", s), pos, segs[s].exp_pos);
      check($sformatf("ab_seg%0d", s), {a, b}, segs[s].exp_ab);
    end

    // rpm=0: no edges, outputs hold
    @(posedge clk); #1 target_rpm_in = 10'd0;
    count_strobes(1000, cnt);
    check("rpm0_edges", cnt, 0);
    check("rpm0_pos", pos, 36);
    check("rpm0_ab", {a, b}, 2'b01);

    // Disable partway through an interval at rpm=600
    @(posedge clk); #1 target_rpm_in = 10'd600;
    count_strobes(50, cnt);
    check("pre_disable_edges", cnt, 0);
    @(posedge clk); #1 enable_in = 1'b0;
    count_strobes(500, cnt);
    check("disabled_edges", cnt, 0);
    check("disabled_pos", pos, 36);
    check("disabled_ab", {a, b}, 2'b01);

    // Re-enable starts from acc=0 with inc_q already loaded: full interval
    @(posedge clk); #1 enable_in = 1'b1; direction_in = 1'b0;
    wait_strobe(1'b0, 400, cyc);
    check("reenable_first_edge", cyc, 100);
    wait_strobe(1'b0, 400, cyc);
    check_range("reenable_spacing", cyc, 99, 101);
    check("reenable_pos", pos, 38);
    check("reenable_ab", {a, b}, 2'b10);

    // Reset while enabled
    @(posedge clk); #1 reset_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_ab", {a, b}, 2'b01);
    check("midreset_pos", pos, 0);
    check("midreset_strobe", strobe, 0);
    @(posedge clk); #1 reset_in = 1'b0;
    wait_strobe(1'b0, 400, cyc);
    check("postreset_first_edge", cyc, 101);
    check("postreset_pos", pos, 1);
    check("postreset_ab", {a, b}, 2'b11);

    // Full-scale rpm on both instances; the MAX_RPM=500 copy follows the clamped rate
    @(posedge clk); #1 reset_in = 1'b1;
    @(posedge clk); #1 reset_in = 1'b0; target_rpm_in = 10'd1023;
    cyc = 0; main_cnt = 0; first_main = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (strobe) begin
        main_cnt++;
        if (first_main == 0) first_main = cyc;
      end
    end while (!cstrobe && cyc < 400);
    check("clamp_first_edge", cyc, 121);
    check("full_first_edge", first_main, 60);
    check("full_edges_before_clamp", main_cnt, 2);
    wait_strobe(1'b1, 400, cyc);
    check("clamp_spacing", cyc, 120);
    check("clamp_pos", cpos, 2);
    check("clamp_ab", {ca, cb}, 2'b10);
    check("clamp_index", cidx, 0);

`ifdef TACH_EMU_INDEX_EN
    check("index_pulses", idx_pulses, 1);
`else
    check("index_pulses", idx_pulses, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
